writeback_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/wb_regfile.sv | 43 ++++
 rtl/writeback_unit.sv | 186 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcode map, flag bit positions,
// writeback FSM encoding and an opcode classifier.
package cpu_pkg;

    localparam logic [4:0] OP_NOP       = 5'h00;
    localparam logic [4:0] OP_ALU_FIRST = 5'h01;
    localparam logic [4:0] OP_ALU_LAST  = 5'h0F;
    localparam logic [4:0] OP_CMP       = 5'h0A;
    localparam logic [4:0] OP_MUL       = 5'h10;
    localparam logic [4:0] OP_LD        = 5'h11;
    localparam logic [4:0] OP_ST        = 5'h12;
    localparam logic [4:0] OP_MOV       = 5'h13;
    localparam logic [4:0] OP_JMP       = 5'h14;
    localparam logic [4:0] OP_JZ        = 5'h15;
    localparam logic [4:0] OP_JC        = 5'h16;
    localparam logic [4:0] OP_HLT       = 5'h17;

    localparam int FLAG_Z  = 3;
    localparam int FLAG_C  = 2;
    localparam int FLAG_AC = 1;
    localparam int FLAG_P  = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        MUL_HI = 1'b1
    } wb_state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_CMP,
        CLS_MUL,
        CLS_LD,
        CLS_ST,
        CLS_MOV,
        CLS_JMP,
        CLS_JZ,
        CLS_JC,
        CLS_HLT,
        CLS_ILLEGAL
    } op_class_t;

    // Everything above OP_HLT is undefined and behaves as a NOP that flags illegal_op.
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        if (op == OP_NOP)                               cls = CLS_NOP;
        else if (op == OP_CMP)                          cls = CLS_CMP;
        else if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) cls = CLS_ALU;
        else if (op == OP_MUL)                          cls = CLS_MUL;
        else if (op == OP_LD)                           cls = CLS_LD;
        else if (op == OP_ST)                           cls = CLS_ST;
        else if (op == OP_MOV)                          cls = CLS_MOV;
        else if (op == OP_JMP)                          cls = CLS_JMP;
        else if (op == OP_JZ)                           cls = CLS_JZ;
        else if (op == OP_JC)                           cls = CLS_JC;
        else if (op == OP_HLT)                          cls = CLS_HLT;
        else                                            cls = CLS_ILLEGAL;
        return cls;
    endfunction

endpackage

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two combinational read ports
// that forward the data being written in the same cycle.
module wb_regfile #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] regs_reg [NREGS];
    logic [NREGS-1:0] wen;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wen
        assign wen[gi] = we && (waddr == AW'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wen[i]) begin
                    regs_reg[i] <= wdata;
                end
            end
        end
    end

    assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs_reg[raddr1];
    assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs_reg[raddr2];

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: commits results to registers, data memory and flags,
// resolves jumps, and sequences the two-cycle multiply writeback.
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int NREGS      = 8,
    parameter int DMEM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  EX_WB_opcode,
    input  logic        EX_WB_am,
    input  logic [2:0]  EX_WB_rd,
    input  logic [3:0]  EX_WB_mem_addr,
    input  logic [5:0]  EX_WB_instr_mem_addr,
    input  logic [15:0] EX_WB_result,
    input  logic        EX_WB_zero_flag,
    input  logic        EX_WB_carry_flag,
    input  logic        EX_WB_ac_flag,
    input  logic        EX_WB_parity_flag,
    input  logic [2:0]  rs1_addr,
    input  logic [2:0]  rs2_addr,
    output logic [7:0]  rs1_data,
    output logic [7:0]  rs2_data,
    output logic [3:0]  flags,
    output logic        stall,
    output logic        redirect_valid,
    output logic [5:0]  redirect_addr,
    output logic        halted,
    output logic        illegal_op
);

    wb_state_t  state_reg;
    logic [3:0] flags_reg;
    logic       redirect_valid_reg;
    logic [5:0] redirect_addr_reg;
    logic       halted_reg;
    logic       illegal_op_reg;
    logic [2:0] mul_rd_reg;
    logic [7:0] mul_hi_reg;

    logic [7:0] dmem_reg [DMEM_DEPTH];
    logic [DMEM_DEPTH-1:0] dmem_wen;

    op_class_t  op_class;
    logic       accept;
    logic [3:0] dmem_addr;
    logic [7:0] ld_data;
    logic [3:0] flags_in;
    logic       flags_we;
    logic       dmem_we;
    logic       jump_taken;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;

    assign op_class  = classify(EX_WB_opcode);
    assign stall     = (state_reg == MUL_HI);
    assign accept    = in_valid && !stall && !halted_reg;
    assign dmem_addr = EX_WB_am ? EX_WB_result[3:0] : EX_WB_mem_addr;
    assign ld_data   = dmem_reg[dmem_addr];

    always_comb begin
        flags_in          = '0;
        flags_in[FLAG_Z]  = EX_WB_zero_flag;
        flags_in[FLAG_C]  = EX_WB_carry_flag;
        flags_in[FLAG_AC] = EX_WB_ac_flag;
        flags_in[FLAG_P]  = EX_WB_parity_flag;
    end

    assign flags_we = accept && (op_class == CLS_ALU || op_class == CLS_CMP || op_class == CLS_MUL);
    assign dmem_we  = accept && (op_class == CLS_ST);

    // Jump conditions look at the flag register as it stood before this instruction.
    always_comb begin
        jump_taken = 1'b0;
        if (accept) begin
            case (op_class)
                CLS_JMP: jump_taken = 1'b1;
                CLS_JZ:  jump_taken = flags_reg[FLAG_Z];
                CLS_JC:  jump_taken = flags_reg[FLAG_C];
                default: jump_taken = 1'b0;
            endcase
        end
    end

    // Single register write port: the MUL high byte owns it during the stall cycle.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = EX_WB_rd;
        rf_wdata = EX_WB_result[7:0];
        if (state_reg == MUL_HI) begin
            rf_we    = 1'b1;
            rf_waddr = mul_rd_reg + 3'd1;
            rf_wdata = mul_hi_reg;
        end else if (accept) begin
            case (op_class)
                CLS_ALU, CLS_MUL, CLS_MOV: rf_we = 1'b1;
                CLS_LD: begin
                    rf_we    = 1'b1;
                    rf_wdata = ld_data;
                end
                default: rf_we = 1'b0;
            endcase
        end
    end

    wb_regfile #(
        .NREGS (NREGS),
        .AW    (3),
        .DW    (8)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    for (genvar gi = 0; gi < DMEM_DEPTH; gi++) begin : g_dmem_wen
        assign dmem_wen[gi] = dmem_we && (dmem_addr == 4'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                if (dmem_wen[i]) begin
                    dmem_reg[i] <= EX_WB_result[7:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            flags_reg          <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_addr_reg  <= '0;
            halted_reg         <= 1'b0;
            illegal_op_reg     <= 1'b0;
            mul_rd_reg         <= '0;
            mul_hi_reg         <= '0;
        end else begin
            redirect_valid_reg <= jump_taken;
            illegal_op_reg     <= accept && (op_class == CLS_ILLEGAL);
            if (jump_taken) begin
                redirect_addr_reg <= EX_WB_instr_mem_addr;
            end
            if (flags_we) begin
                flags_reg <= flags_in;
            end
            if (accept && op_class == CLS_HLT) begin
                halted_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    // Capture the high half now so upstream may change inputs during the stall.
                    if (accept && op_class == CLS_MUL) begin
                        state_reg  <= MUL_HI;
                        mul_rd_reg <= EX_WB_rd;
                        mul_hi_reg <= EX_WB_result[15:8];
                    end
                end
                MUL_HI:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign flags          = flags_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_addr  = redirect_addr_reg;
    assign halted         = halted_reg;
    assign illegal_op     = illegal_op_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: an architectural model predicts each
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  EX_WB_opcode;
    logic        EX_WB_am;
    logic [2:0]  EX_WB_rd;
    logic [3:0]  EX_WB_mem_addr;
    logic [5:0]  EX_WB_instr_mem_addr;
    logic [15:0] EX_WB_result;
    logic        EX_WB_zero_flag;
    logic        EX_WB_carry_flag;
    logic        EX_WB_ac_flag;
    logic        EX_WB_parity_flag;
    logic [2:0]  rs1_addr;
    logic [2:0]  rs2_addr;
    logic [7:0]  rs1_data;
    logic [7:0]  rs2_data;
    logic [3:0]  flags;
    logic        stall;
    logic        redirect_valid;
    logic [5:0]  redirect_addr;
    logic        halted;
    logic        illegal_op;

    always #5 clk = ~clk;

    writeback_unit #(.NREGS(8), .DMEM_DEPTH(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .EX_WB_opcode         (EX_WB_opcode),
        .EX_WB_am             (EX_WB_am),
        .EX_WB_rd             (EX_WB_rd),
        .EX_WB_mem_addr       (EX_WB_mem_addr),
        .EX_WB_instr_mem_addr (EX_WB_instr_mem_addr),
        .EX_WB_result         (EX_WB_result),
        .EX_WB_zero_flag      (EX_WB_zero_flag),
        .EX_WB_carry_flag     (EX_WB_carry_flag),
        .EX_WB_ac_flag        (EX_WB_ac_flag),
        .EX_WB_parity_flag    (EX_WB_parity_flag),
        .rs1_addr             (rs1_addr),
        .rs2_addr             (rs2_addr),
        .rs1_data             (rs1_data),
        .rs2_data             (rs2_data),
        .flags                (flags),
        .stall                (stall),
        .redirect_valid       (redirect_valid),
        .redirect_addr        (redirect_addr),
        .halted               (halted),
        .illegal_op           (illegal_op)
    );

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [4:0]  op;
        logic        am;
        logic [2:0]  rd;
        logic [3:0]  maddr;
        logic [5:0]  jaddr;
        logic [15:0] res;
        logic [3:0]  fl;   // {Z,C,AC,P}
        logic [2:0]  rs1;
        logic [2:0]  rs2;
    } stim_t;

    typedef struct packed {
        logic [7:0] rs1;
        logic [7:0] rs2;
        logic [3:0] flags;
        logic       stall;
        logic       rv;
        logic [5:0] ra;
        logic       halted;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } pw_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    // Architectural model state
    logic [7:0] m_regs [8];
    logic [7:0] m_mem  [16];
    logic [3:0] m_flags;
    logic       m_halted;
    logic       m_rv;
    logic [5:0] m_ra;
    logic       m_ill;
    pw_t        pend_q[$];

    function automatic stim_t ins(input logic [4:0] op, input logic [2:0] rd, input logic [15:0] res,
                                  input logic [3:0] fl, input logic am, input logic [3:0] maddr,
                                  input logic [5:0] jaddr, input logic [2:0] rs1, input logic [2:0] rs2);
        stim_t s;
        s.rst = 1'b0; s.valid = 1'b1; s.op = op; s.am = am; s.rd = rd; s.maddr = maddr;
        s.jaddr = jaddr; s.res = res; s.fl = fl; s.rs1 = rs1; s.rs2 = rs2;
        return s;
    endfunction

    function automatic stim_t bubble(input logic [2:0] rs1, input logic [2:0] rs2);
        stim_t s;
        s = ins(5'h00, 3'd0, 16'h0, 4'h0, 1'b0, 4'h0, 6'h0, rs1, rs2);
        s.valid = 1'b0;
        return s;
    endfunction

    function automatic stim_t rst_item(input logic [2:0] rs1, input logic [2:0] rs2);
        stim_t s;
        s = bubble(rs1, rs2);
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_flags = 4'h0; m_halted = 1'b0; m_rv = 1'b0; m_ra = 6'h0; m_ill = 1'b0;
        pend_q.delete();
    endtask

    // Predicts this cycle's visible outputs, then advances the model past the clock edge.
    task automatic model_step(input stim_t s, output exp_t e, output bit consumed);
        bit         accept, we, taken;
        logic [2:0] wa, hi_rd;
        logic [7:0] wd;
        logic [3:0] addr;
        pw_t        pw;
        if (s.rst) m_reset();
        e.stall  = (pend_q.size() != 0);
        e.flags  = m_flags;
        e.rv     = m_rv;
        e.ra     = m_ra;
        e.halted = m_halted;
        e.ill    = m_ill;
        accept   = !s.rst && s.valid && !e.stall && !m_halted;
        consumed = s.rst || !s.valid || accept || m_halted;
        we = 0; wa = 0; wd = 0; taken = 0;
        addr  = s.am ? s.res[3:0] : s.maddr;
        m_rv  = 1'b0;
        m_ill = 1'b0;
        if (e.stall) begin
            pw = pend_q.pop_front();
            we = 1; wa = pw.a; wd = pw.d;
        end else if (accept) begin
            if (s.op >= 5'h01 && s.op <= 5'h0F) begin
                if (s.op != 5'h0A) begin we = 1; wa = s.rd; wd = s.res[7:0]; end
                m_flags = s.fl;
            end else begin
                case (s.op)
                    5'h10: begin
                        we = 1; wa = s.rd; wd = s.res[7:0]; m_flags = s.fl;
                        hi_rd = 3'((int'(s.rd) + 1) % 8);
                        pw.a = hi_rd; pw.d = s.res[15:8];
                        pend_q.push_back(pw);
                    end
                    5'h11: begin we = 1; wa = s.rd; wd = m_mem[addr]; end
                    5'h12: m_mem[addr] = s.res[7:0];
                    5'h13: begin we = 1; wa = s.rd; wd = s.res[7:0]; end
                    5'h14: taken = 1;
                    5'h15: taken = e.flags[3];
                    5'h16: taken = e.flags[2];
                    5'h17: m_halted = 1'b1;
                    default: if (s.op >= 5'h18) m_ill = 1'b1;
                endcase
            end
        end
        e.rs1 = (we && wa == s.rs1) ? wd : m_regs[s.rs1];
        e.rs2 = (we && wa == s.rs2) ? wd : m_regs[s.rs2];
        if (we) m_regs[wa] = wd;
        if (taken) begin m_rv = 1'b1; m_ra = s.jaddr; end
    endtask

    task automatic drive(input stim_t s);
        rst                  = s.rst;
        in_valid             = s.valid;
        EX_WB_opcode         = s.op;
        EX_WB_am             = s.am;
        EX_WB_rd             = s.rd;
        EX_WB_mem_addr       = s.maddr;
        EX_WB_instr_mem_addr = s.jaddr;
        EX_WB_result         = s.res;
        EX_WB_zero_flag      = s.fl[3];
        EX_WB_carry_flag     = s.fl[2];
        EX_WB_ac_flag        = s.fl[1];
        EX_WB_parity_flag    = s.fl[0];
        rs1_addr             = s.rs1;
        rs2_addr             = s.rs2;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction, away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cyc++;
                $display("cyc %0d rs1=%h rs2=%h flags=%b stall=%b redir=%b/%h halted=%b ill=%b",
                         cyc, rs1_data, rs2_data, flags, stall, redirect_valid, redirect_addr, halted, illegal_op);
                chk("rs1_data", 16'(rs1_data), 16'(e.rs1));
                chk("rs2_data", 16'(rs2_data), 16'(e.rs2));
                chk("flags", 16'(flags), 16'(e.flags));
                chk("stall", 16'(stall), 16'(e.stall));
                chk("redirect_valid", 16'(redirect_valid), 16'(e.rv));
                chk("redirect_addr", 16'(redirect_addr), 16'(e.ra));
                chk("halted", 16'(halted), 16'(e.halted));
                chk("illegal_op", 16'(illegal_op), 16'(e.ill));
            end
        end
    end

    initial begin
        stim_t s;
        exp_t  e;
        bit    consumed;
        logic [4:0] op;

        drive(rst_item(3'd0, 3'd0));
        m_reset();

        stim_q.push_back(rst_item(3'd0, 3'd0));
        stim_q.push_back(bubble(3'd0, 3'd0));
        // Reset during the MUL high-byte cycle
        stim_q.push_back(ins(5'h10, 3'd3, 16'hABCD, 4'b0000, 1'b0, 4'h0, 6'h0, 3'd3, 3'd4));
        stim_q.push_back(rst_item(3'd3, 3'd4));
        stim_q.push_back(bubble(3'd3, 3'd4));
        stim_q.push_back(bubble(3'd3, 3'd4));
        // ALU write seen through the bypass
        stim_q.push_back(ins(5'h01, 3'd2, 16'h0042, 4'b0100, 1'b0, 4'h0, 6'h0, 3'd2, 3'd0));
        stim_q.push_back(bubble(3'd2, 3'd0));
        // MUL into r7 wraps the high byte to r0; MOV is held through the stall
        stim_q.push_back(ins(5'h10, 3'd7, 16'h1234, 4'b0011, 1'b0, 4'h0, 6'h0, 3'd7, 3'd0));
        stim_q.push_back(ins(5'h13, 3'd5, 16'h0077, 4'b1111, 1'b0, 4'h0, 6'h0, 3'd0, 3'd7));
        stim_q.push_back(bubble(3'd5, 3'd0));
        // Store direct, load register-indirect
        stim_q.push_back(ins(5'h12, 3'd0, 16'h009E, 4'b1111, 1'b0, 4'h5, 6'h0, 3'd0, 3'd1));
        stim_q.push_back(ins(5'h11, 3'd1, 16'h0005, 4'b1111, 1'b1, 4'hA, 6'h0, 3'd1, 3'd0));
        stim_q.push_back(bubble(3'd1, 3'd0));
        // Branches
        stim_q.push_back(ins(5'h0A, 3'd6, 16'h00FF, 4'b1000, 1'b0, 4'h0, 6'h0, 3'd6, 3'd0));
        stim_q.push_back(ins(5'h15, 3'd0, 16'h0000, 4'b0100, 1'b0, 4'h0, 6'h2A, 3'd0, 3'd0));
        stim_q.push_back(ins(5'h16, 3'd0, 16'h0000, 4'b0100, 1'b0, 4'h0, 6'h15, 3'd0, 3'd0));
        stim_q.push_back(bubble(3'd0, 3'd0));
        stim_q.push_back(bubble(3'd0, 3'd0));
        // Randomized mix, no halt
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 22));
            s = ins(op, 3'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                    6'($urandom), 3'($urandom), 3'($urandom));
            s.valid = ($urandom_range(0, 9) != 0);
            stim_q.push_back(s);
        end
        // Illegal opcode, halt, then an ADD that must be ignored
        stim_q.push_back(rst_item(3'd0, 3'd0));
        stim_q.push_back(bubble(3'd0, 3'd0));
        stim_q.push_back(ins(5'h1C, 3'd0, 16'h00AA, 4'b1010, 1'b0, 4'h0, 6'h0, 3'd0, 3'd0));
        stim_q.push_back(ins(5'h17, 3'd0, 16'h0000, 4'b0000, 1'b0, 4'h0, 6'h0, 3'd0, 3'd0));
        stim_q.push_back(ins(5'h01, 3'd0, 16'h0055, 4'b1111, 1'b0, 4'h0, 6'h0, 3'd0, 3'd0));
        stim_q.push_back(bubble(3'd0, 3'd0));
        stim_q.push_back(bubble(3'd0, 3'd0));
        stim_q.push_back(bubble(3'd0, 3'd0));

        while (stim_q.size() != 0) begin
            @(posedge clk);
            #1;
            s = stim_q[0];
            drive(s);
            model_step(s, e, consumed);
            exp_q.push_back(e);
            if (consumed) void'(stim_q.pop_front());
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
